// File: rtl/inst_mem_port_pkg.sv
// inst_mem_port_pkg: word geometry and FSM encoding shared by the instruction fetch port
package inst_mem_port_pkg;
  localparam int XLEN = 32;
  localparam int INST_BYTES = 4;
  typedef enum logic [1:0] {IDLE, READ, RESP} state_e;
endpackage

// File: rtl/inst_mem_port.sv
// inst_mem_port: fetches a little-endian instruction word byte by byte from a shared synchronous RAM port
module inst_mem_port
  import inst_mem_port_pkg::*;
(
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            req_valid,
  input  logic [XLEN-1:0] req_addr,
  output logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  input  logic            flush,
  output logic            bus_req,
  input  logic            bus_gnt,
  output logic [XLEN-1:0] ram_a,
  input  logic [7:0]      ram_din,
  output logic            ram_wr
);
  state_e state_q, state_d;
  logic [XLEN-1:0] base_q, base_d, ram_a_q, ram_a_d, resp_q, resp_d;
  logic [2:0] issue_q, issue_d, cap_q, cap_d;
  logic pend_q, pend_d;
  logic [INST_BYTES-1:0][7:0] lanes_q, lanes_d;
  assign ram_wr = 1'b0;
  assign ram_a = ram_a_d;
  // outside RESP the last delivered word is shown so resp_data never wanders mid-fetch
  assign resp_data = state_q == RESP ? lanes_q : resp_q;
  assign bus_req = !flush && ((state_q == IDLE && req_valid) || state_q == READ);
  assign resp_ready = state_q == RESP && rdy_in && !flush;
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    issue_d = issue_q;
    cap_d = cap_q;
    pend_d = pend_q;
    lanes_d = lanes_q;
    resp_d = resp_q;
    ram_a_d = ram_a_q;
    if (flush) begin
      state_d = IDLE;
      pend_d = 1'b0;
      lanes_d = '0;
    end else if (!rdy_in) begin
      pend_d = 1'b0;
    end else if (state_q == IDLE && req_valid && bus_gnt) begin
      base_d = req_addr;
      ram_a_d = req_addr;
      issue_d = 3'd1;
      cap_d = 3'd0;
      pend_d = 1'b1;
      state_d = READ;
    end else if (state_q == READ) begin
      if (pend_q) begin
        lanes_d[cap_q[1:0]] = ram_din;
        cap_d = cap_q + 3'd1;
      end
      // a stall dropped the in-flight read, so restart issuing from the next byte still missing
      if (!pend_q) begin
        ram_a_d = base_q + XLEN'(cap_q);
        issue_d = cap_q + 3'd1;
        pend_d = 1'b1;
      end else if (issue_q < 3'(INST_BYTES)) begin
        ram_a_d = base_q + XLEN'(issue_q);
        issue_d = issue_q + 3'd1;
        pend_d = 1'b1;
      end else begin
        pend_d = 1'b0;
      end
      if (pend_q && cap_q == 3'(INST_BYTES - 1)) state_d = RESP;
    end else if (state_q == RESP) begin
      resp_d = lanes_q;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      base_q <= '0;
      issue_q <= '0;
      cap_q <= '0;
      pend_q <= 1'b0;
      lanes_q <= '0;
      resp_q <= '0;
      ram_a_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      issue_q <= issue_d;
      cap_q <= cap_d;
      pend_q <= pend_d;
      lanes_q <= lanes_d;
      resp_q <= resp_d;
      ram_a_q <= ram_a_d;
    end
  end
endmodule

// File: tb/tb_inst_mem_port.sv
// tb_inst_mem_port: directed and random fetches checked against a transaction-level latency/word model
module tb_inst_mem_port;
  logic clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b0, req_valid = 1'b0, flush = 1'b0, bus_gnt = 1'b0;
  logic [31:0] req_addr = '0;
  logic [7:0] ram_din = '0;
  logic resp_ready, bus_req, ram_wr;
  logic [31:0] resp_data, ram_a;
  int n_chk = 0, n_fail = 0;
  bit busy = 0, stall_run = 0;
  int rem = 0;
  logic [31:0] word = '0, last_word = '0;
  logic [31:0] obs_ram_a, obs_resp_data;
  logic obs_resp_ready, obs_bus_req;

  always #5 clk_in = ~clk_in;

  inst_mem_port dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .req_valid(req_valid), .req_addr(req_addr),
    .resp_ready(resp_ready), .resp_data(resp_data), .flush(flush), .bus_req(bus_req),
    .bus_gnt(bus_gnt), .ram_a(ram_a), .ram_din(ram_din), .ram_wr(ram_wr)
  );

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] h;
    if (a == 32'd0) return 8'h13;
    if (a == 32'd1) return 8'h05;
    if (a == 32'd2) return 8'hA0;
    if (a == 32'd3) return 8'h00;
    h = a * 32'h9E3779B1;
    return h[31:24] ^ a[7:0];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {byte_at(a + 32'd3), byte_at(a + 32'd2), byte_at(a + 32'd1), byte_at(a)};
  endfunction

  // synchronous RAM: data for the address seen at the previous active edge
  always @(posedge clk_in) if (rdy_in) ram_din <= byte_at(ram_a);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rv, input logic [31:0] addr, input logic gnt, input logic rdy,
                      input logic fl, input logic rs);
    bit in_read;
    @(negedge clk_in);
    req_valid = rv; req_addr = addr; bus_gnt = gnt; rdy_in = rdy; flush = fl; rst_in = rs;
    #1;
    obs_ram_a = ram_a; obs_resp_data = resp_data; obs_resp_ready = resp_ready; obs_bus_req = bus_req;
    chk("ram_wr", ram_wr, 0);
    if (rs) begin
      busy = 0;
      last_word = '0;
    end else if (!busy) begin
      chk("idle_bus_req", bus_req, rv && !fl);
      chk("idle_resp_ready", resp_ready, 0);
      chk("idle_resp_data", resp_data, last_word);
      if (rv && gnt && rdy && !fl) begin
        chk("accept_ram_a", ram_a, addr);
        busy = 1; rem = 5; stall_run = 0; word = word_at(addr);
      end
    end else if (fl) begin
      chk("flush_bus_req", bus_req, 0);
      chk("flush_resp_ready", resp_ready, 0);
      busy = 0;
    end else begin
      in_read = rem >= 2;
      chk("busy_bus_req", bus_req, in_read);
      if (rdy) begin
        stall_run = 0;
        rem--;
        chk("resp_ready", resp_ready, rem == 0);
        if (rem == 0) begin
          chk("resp_data", resp_data, word);
          busy = 0;
          last_word = word;
        end
      end else begin
        chk("stall_resp_ready", resp_ready, 0);
        if (in_read && !stall_run) rem++;
        stall_run = 1;
      end
    end
    @(posedge clk_in);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, '0, 0, 1, 0, 0);
  endtask

  initial begin
    logic r, f, s;
    step(0, '0, 0, 1, 0, 1);
    step(0, '0, 0, 0, 0, 1);
    idle(1);
    chk("rst_ram_a", obs_ram_a, 0);
    chk("rst_bus_req", obs_bus_req, 0);
    chk("rst_resp_data", obs_resp_data, 0);
    chk("rst_resp_ready", obs_resp_ready, 0);
    step(1, 32'h0, 1, 1, 0, 0);
    idle(5);
    chk("basic_ready", obs_resp_ready, 1);
    chk("basic_word", obs_resp_data, 32'h00A00513);
    idle(1);
    repeat (3) begin
      step(1, 32'h40, 0, 1, 0, 0);
      chk("gw_bus_req", obs_bus_req, 1);
    end
    step(1, 32'h40, 1, 1, 0, 0);
    chk("gw_ram_a", obs_ram_a, 32'h40);
    idle(5);
    chk("gw_ready", obs_resp_ready, 1);
    step(1, 32'h100, 1, 1, 0, 0);
    idle(1);
    step(0, '0, 0, 1, 1, 0);
    chk("fl_ready", obs_resp_ready, 0);
    chk("fl_bus_req", obs_bus_req, 0);
    step(1, 32'h200, 1, 1, 0, 0);
    chk("fl_ram_a", obs_ram_a, 32'h200);
    idle(5);
    chk("fl_ready2", obs_resp_ready, 1);
    chk("fl_word", obs_resp_data, word_at(32'h200));
    step(1, 32'h300, 1, 1, 0, 0);
    idle(2);
    step(0, '0, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0);
    idle(1);
    chk("stall_reissue", obs_ram_a, 32'h302);
    idle(3);
    chk("stall_ready", obs_resp_ready, 1);
    chk("stall_word", obs_resp_data, word_at(32'h300));
    step(1, 32'h400, 1, 1, 0, 0);
    idle(4);
    step(1, 32'h404, 1, 1, 0, 0);
    chk("b2b_resp", obs_resp_ready, 1);
    chk("b2b_no_req", obs_bus_req, 0);
    step(1, 32'h404, 1, 1, 0, 0);
    chk("b2b_accept", obs_ram_a, 32'h404);
    idle(5);
    chk("b2b_ready", obs_resp_ready, 1);
    step(1, 32'h500, 1, 1, 0, 0);
    idle(2);
    step(0, '0, 0, 1, 0, 1);
    idle(1);
    chk("rr_ram_a", obs_ram_a, 0);
    chk("rr_bus_req", obs_bus_req, 0);
    chk("rr_resp_data", obs_resp_data, 0);
    idle(6);
    step(1, 32'hFFFF_FFFE, 1, 1, 0, 0);
    idle(5);
    chk("wrap_word", obs_resp_data, {8'h05, 8'h13, byte_at(32'hFFFF_FFFF), byte_at(32'hFFFF_FFFE)});
    step(1, 32'h600, 1, 1, 1, 0);
    chk("fl_accept_bus_req", obs_bus_req, 0);
    idle(6);
    step(1, 32'h700, 1, 1, 0, 0);
    idle(4);
    step(0, '0, 0, 1, 1, 0);
    chk("fl_resp_ready", obs_resp_ready, 0);
    idle(2);
    repeat (800) begin
      s = $urandom_range(0, 299) == 0;
      r = $urandom_range(0, 5) != 0;
      f = r && $urandom_range(0, 39) == 0;
      step(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) != 0, r, f, s);
    end
    idle(10);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
